// File: rtl/score_pkg.sv
// Shared constants, state encoding and lane-count helper for the whack-a-mole score keeper.
package score_pkg;

    localparam int unsigned LIVES_INIT   = 3;
    localparam int unsigned SCORE_MAX    = 9999;
    localparam int unsigned COMBO_THRESH = 5;

    localparam int unsigned N_LANES = 4;
    localparam int unsigned POS_W   = 5;
    localparam int unsigned SCORE_W = 14;
    localparam int unsigned BCD_W   = 16;
    localparam int unsigned COMBO_W = 8;
    localparam int unsigned LIVES_W = 2;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned PTS_W   = 4;

    localparam logic [POS_W-1:0] POS_NONE      = POS_W'(0);
    localparam logic [POS_W-1:0] POS_EXPIRE    = POS_W'(11);
    localparam logic [POS_W-1:0] POS_FIELD_MIN = POS_W'(1);
    localparam logic [POS_W-1:0] POS_FIELD_MAX = POS_W'(9);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // Number of lanes flagged in a per-lane event vector.
    function automatic logic [CNT_W-1:0] count_lanes(input logic [N_LANES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(N_LANES); i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/score_keeper_bin2bcd.sv
// Combinational 14-bit binary to 4-digit BCD converter (shift-and-add-3).
module bin2bcd (
    input  logic [score_pkg::SCORE_W-1:0] bin,
    output logic [score_pkg::BCD_W-1:0]   bcd
);
    import score_pkg::*;

    always_comb begin
        bcd = '0;
        for (int i = int'(SCORE_W) - 1; i >= 0; i--) begin
            for (int d = 0; d < 4; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) begin
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
                end
            end
            bcd = {bcd[BCD_W-2:0], bin[i]};
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Score, combo and lives tracking for a four-lane whack-a-mole game with IDLE/PLAY/OVER control.
module score_keeper #(
    parameter int unsigned LIVES_INIT   = score_pkg::LIVES_INIT,
    parameter int unsigned SCORE_MAX    = score_pkg::SCORE_MAX,
    parameter int unsigned COMBO_THRESH = score_pkg::COMBO_THRESH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          hit_0,
    input  logic                          hit_1,
    input  logic                          hit_2,
    input  logic                          hit_3,
    input  logic [score_pkg::POS_W-1:0]   pos_0,
    input  logic [score_pkg::POS_W-1:0]   pos_1,
    input  logic [score_pkg::POS_W-1:0]   pos_2,
    input  logic [score_pkg::POS_W-1:0]   pos_3,
    output logic [score_pkg::BCD_W-1:0]   score_bcd,
    output logic [score_pkg::COMBO_W-1:0] combo,
    output logic [score_pkg::LIVES_W-1:0] lives,
    output logic                          playing,
    output logic                          game_over
);
    import score_pkg::*;

    state_t               state_q, state_d;
    logic [N_LANES-1:0]   hit_in, hit_q, flag_q, flag_d, new_hit, miss;
    logic [POS_W-1:0]     pos_in [N_LANES];
    logic [POS_W-1:0]     pos_q  [N_LANES];
    logic [CNT_W-1:0]     n_hits, n_miss;
    logic [PTS_W-1:0]     points;
    logic [SCORE_W:0]     score_sum;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [COMBO_W:0]     combo_sum;
    logic [COMBO_W-1:0]   combo_d;
    logic [LIVES_W-1:0]   lives_d;
    logic                 enter_play;

    assign hit_in    = {hit_3, hit_2, hit_1, hit_0};
    assign pos_in[0] = pos_0;
    assign pos_in[1] = pos_1;
    assign pos_in[2] = pos_2;
    assign pos_in[3] = pos_3;

    // Hit edges, unhit expiries and the "already hit" flag that suppresses a miss.
    always_comb begin
        new_hit = '0;
        miss    = '0;
        flag_d  = flag_q;
        for (int k = 0; k < int'(N_LANES); k++) begin
            new_hit[k] = hit_in[k] & ~hit_q[k];
            miss[k]    = (pos_in[k] == POS_EXPIRE) && (pos_q[k] >= POS_FIELD_MIN) &&
                         (pos_q[k] <= POS_FIELD_MAX) && !flag_q[k] && !new_hit[k];
            if (new_hit[k]) begin
                flag_d[k] = 1'b1;
            end else if ((pos_in[k] == POS_EXPIRE && pos_q[k] != POS_EXPIRE) ||
                         pos_in[k] == POS_NONE) begin
                flag_d[k] = 1'b0;
            end
        end
    end

    // Next score/combo/lives; points are weighted by the combo held before this edge.
    always_comb begin
        n_hits    = count_lanes(new_hit);
        n_miss    = count_lanes(miss);
        points    = (32'(combo) >= COMBO_THRESH) ? PTS_W'({n_hits, 1'b0}) : PTS_W'(n_hits);
        score_sum = (SCORE_W+1)'(score_q) + (SCORE_W+1)'(points);
        score_d   = (32'(score_sum) > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(score_sum);
        combo_sum = (COMBO_W+1)'(combo) + (COMBO_W+1)'(n_hits);
        if (|miss) begin
            combo_d = '0;
        end else if (combo_sum[COMBO_W]) begin
            combo_d = '1;
        end else begin
            combo_d = combo_sum[COMBO_W-1:0];
        end
        lives_d = (32'(n_miss) >= 32'(lives)) ? '0 : lives - LIVES_W'(n_miss);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)           state_d = ST_PLAY;
            ST_PLAY: if (lives_d == '0)   state_d = ST_OVER;
            ST_OVER: if (start)           state_d = ST_PLAY;
            default:                      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        playing   = (state_q == ST_PLAY);
        game_over = (state_q == ST_OVER);
    end

    assign enter_play = (state_q != ST_PLAY) && (state_d == ST_PLAY);

    // Lane history runs in every state; game counters move only in PLAY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_q   <= '0;
            flag_q  <= '0;
            score_q <= '0;
            combo   <= '0;
            lives   <= '0;
            for (int k = 0; k < int'(N_LANES); k++) begin
                pos_q[k] <= '0;
            end
        end else begin
            hit_q  <= hit_in;
            flag_q <= flag_d;
            for (int k = 0; k < int'(N_LANES); k++) begin
                pos_q[k] <= pos_in[k];
            end
            if (enter_play) begin
                score_q <= '0;
                combo   <= '0;
                lives   <= LIVES_W'(LIVES_INIT);
            end else if (state_q == ST_PLAY) begin
                score_q <= score_d;
                combo   <= combo_d;
                lives   <= lives_d;
            end
        end
    end

    bin2bcd u_bin2bcd (
        .bin (score_q),
        .bcd (score_bcd)
    );

endmodule

// File: tb/tb_score_keeper.sv
// Directed test of score_keeper: game flow, combo weighting, misses, game over, saturation, reset.
module tb_score_keeper;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  hit;
    logic [4:0]  pos [4];
    logic [15:0] score_bcd;
    logic [7:0]  combo;
    logic [1:0]  lives;
    logic        playing;
    logic        game_over;

    int errors = 0;
    int checks = 0;

    score_keeper dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .hit_0     (hit[0]),
        .hit_1     (hit[1]),
        .hit_2     (hit[2]),
        .hit_3     (hit[3]),
        .pos_0     (pos[0]),
        .pos_1     (pos[1]),
        .pos_2     (pos[2]),
        .pos_3     (pos[3]),
        .score_bcd (score_bcd),
        .combo     (combo),
        .lives     (lives),
        .playing   (playing),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 1'b0;
        hit   = 4'h0;
        for (int k = 0; k < 4; k++) pos[k] = 5'd0;
    endtask

    task automatic new_game();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL reset_score: got %h want 0000", score_bcd); end
        checks++; if (combo !== 8'd0) begin errors++; $display("FAIL reset_combo: got %0d want 0", combo); end
        checks++; if (lives !== 2'd0) begin errors++; $display("FAIL reset_lives: got %0d want 0", lives); end
        checks++; if ({playing, game_over} !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", {playing, game_over}); end
        rst_n = 1'b1;
        hit[1] = 1'b1; pos[1] = 5'd5;
        tick();
        checks++; if ({score_bcd, combo, playing} !== {16'h0000, 8'd0, 1'b0}) begin
            errors++; $display("FAIL idle_hit_ignored: score=%h combo=%0d playing=%b want 0000/0/0", score_bcd, combo, playing); end
    endtask

    task automatic test_start();
        new_game();
        checks++; if ({playing, game_over} !== 2'b10) begin errors++; $display("FAIL start_state: got %b want 10", {playing, game_over}); end
        checks++; if (lives !== 2'd3) begin errors++; $display("FAIL start_lives: got %0d want 3", lives); end
        checks++; if ({score_bcd, combo} !== {16'h0000, 8'd0}) begin
            errors++; $display("FAIL start_clear: score=%h combo=%0d want 0000/0", score_bcd, combo); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({playing, lives} !== {1'b1, 2'd3}) begin
            errors++; $display("FAIL start_in_play_ignored: playing=%b lives=%0d want 1/3", playing, lives); end
    endtask

    task automatic test_combo();
        new_game();
        for (int i = 0; i < 5; i++) begin
            pos[0] = 5'd5; hit[0] = 1'b1; tick();
            pos[0] = 5'd11; tick();
            hit[0] = 1'b0; pos[0] = 5'd0; tick();
        end
        checks++; if ({combo, score_bcd} !== {8'd5, 16'h0005}) begin
            errors++; $display("FAIL combo_five: combo=%0d score=%h want 5/0005", combo, score_bcd); end
        checks++; if (lives !== 2'd3) begin errors++; $display("FAIL combo_hit_expiry_no_miss: lives=%0d want 3", lives); end
        pos[0] = 5'd5; hit[0] = 1'b1; tick();
        checks++; if ({combo, score_bcd} !== {8'd6, 16'h0007}) begin
            errors++; $display("FAIL combo_double_points: combo=%0d score=%h want 6/0007", combo, score_bcd); end
    endtask

    task automatic test_miss_with_hit();
        new_game();
        for (int i = 0; i < 2; i++) begin
            pos[0] = 5'd5; hit[0] = 1'b1; tick();
            hit[0] = 1'b0; tick();
        end
        pos[2] = 5'd5; tick();
        pos[2] = 5'd11; pos[1] = 5'd3; hit[1] = 1'b1; tick();
        checks++; if (combo !== 8'd0) begin errors++; $display("FAIL miss_combo_clear: got %0d want 0", combo); end
        checks++; if (lives !== 2'd2) begin errors++; $display("FAIL miss_lives: got %0d want 2", lives); end
        checks++; if (score_bcd !== 16'h0003) begin errors++; $display("FAIL miss_hit_scored: got %h want 0003", score_bcd); end
    endtask

    task automatic test_game_over();
        new_game();
        pos[2] = 5'd4; hit[2] = 1'b1; tick();
        hit[2] = 1'b0; pos[0] = 5'd5; pos[1] = 5'd5; pos[3] = 5'd5; tick();
        pos[0] = 5'd11; pos[1] = 5'd11; pos[3] = 5'd11; tick();
        checks++; if ({lives, game_over, playing} !== {2'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL over_enter: lives=%0d game_over=%b playing=%b want 0/1/0", lives, game_over, playing); end
        checks++; if (score_bcd !== 16'h0001) begin errors++; $display("FAIL over_final_score: got %h want 0001", score_bcd); end
        for (int k = 0; k < 4; k++) pos[k] = 5'd0;
        tick();
        pos[2] = 5'd5; hit[2] = 1'b1; tick();
        checks++; if ({score_bcd, combo, lives, game_over} !== {16'h0001, 8'd0, 2'd0, 1'b1}) begin
            errors++; $display("FAIL over_hold: score=%h combo=%0d lives=%0d go=%b want 0001/0/0/1", score_bcd, combo, lives, game_over); end
        start = 1'b1; hit = 4'h0; for (int k = 0; k < 4; k++) pos[k] = 5'd0; tick();
        start = 1'b0;
        checks++; if ({playing, lives, score_bcd} !== {1'b1, 2'd3, 16'h0000}) begin
            errors++; $display("FAIL over_restart: playing=%b lives=%0d score=%h want 1/3/0000", playing, lives, score_bcd); end
        for (int k = 0; k < 4; k++) pos[k] = 5'd5;
        tick();
        for (int k = 0; k < 4; k++) pos[k] = 5'd11;
        tick();
        checks++; if ({lives, game_over} !== {2'd0, 1'b1}) begin
            errors++; $display("FAIL lives_floor: lives=%0d game_over=%b want 0/1", lives, game_over); end
    endtask

    task automatic test_saturation();
        new_game();
        for (int k = 0; k < 4; k++) pos[k] = 5'd5;
        for (int i = 0; i < 4; i++) begin
            hit[0] = 1'b1; tick();
            hit[0] = 1'b0; tick();
        end
        hit = 4'hF; tick();
        checks++; if ({score_bcd, combo} !== {16'h0008, 8'd8}) begin
            errors++; $display("FAIL quad_hit_low_combo: score=%h combo=%0d want 0008/8", score_bcd, combo); end
        hit = 4'h0; tick();
        for (int i = 0; i < 1248; i++) begin
            hit = 4'hF; tick();
            if (i == 0) begin
                checks++; if (score_bcd !== 16'h0016) begin errors++; $display("FAIL quad_hit_eight_points: got %h want 0016", score_bcd); end
            end
            hit = 4'h0; tick();
        end
        checks++; if (score_bcd !== 16'h9992) begin errors++; $display("FAIL long_run_score: got %h want 9992", score_bcd); end
        checks++; if (combo !== 8'd255) begin errors++; $display("FAIL combo_saturate: got %0d want 255", combo); end
        hit = 4'b0111; tick();
        checks++; if (score_bcd !== 16'h9998) begin errors++; $display("FAIL score_9998: got %h want 9998", score_bcd); end
        hit = 4'h0; tick();
        hit[0] = 1'b1; tick();
        checks++; if (score_bcd !== 16'h9999) begin errors++; $display("FAIL score_saturate: got %h want 9999", score_bcd); end
        hit[0] = 1'b0; tick();
        hit[0] = 1'b1; tick();
        checks++; if (score_bcd !== 16'h9999) begin errors++; $display("FAIL score_hold_max: got %h want 9999", score_bcd); end
        checks++; if ({playing, lives} !== {1'b1, 2'd3}) begin
            errors++; $display("FAIL saturate_state: playing=%b lives=%0d want 1/3", playing, lives); end
    endtask

    task automatic test_reset_priority();
        new_game();
        pos[0] = 5'd5; hit[0] = 1'b1; tick();
        hit[0] = 1'b0; tick();
        checks++; if (score_bcd !== 16'h0001) begin errors++; $display("FAIL prio_setup: got %h want 0001", score_bcd); end
        rst_n = 1'b0; hit[0] = 1'b1; start = 1'b1; tick();
        checks++; if ({score_bcd, combo, lives, playing, game_over} !== {16'h0000, 8'd0, 2'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_priority: score=%h combo=%0d lives=%0d p=%b go=%b want 0000/0/0/0/0",
                               score_bcd, combo, lives, playing, game_over); end
        rst_n = 1'b1; start = 1'b0; tick();
        checks++; if ({playing, score_bcd} !== {1'b0, 16'h0000}) begin
            errors++; $display("FAIL reset_priority_idle: playing=%b score=%h want 0/0000", playing, score_bcd); end
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_start();
        test_combo();
        test_miss_with_hit();
        test_game_over();
        test_saturation();
        test_reset_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
